// File: rtl/lgn_pkg.sv
// lgn_pkg: shared defaults and FSM state type for the category argmax block.
//   DEF_CATEGORIES        default number of output classes
//   DEF_BITS_PER_CATEGORY default gate-output bits voting for each class
//   DEF_CHUNK             default bits per input beat
//   state_t               ACCUM (taking beats) / DONE (holding result)
package lgn_pkg;
    localparam int DEF_CATEGORIES        = 10;
    localparam int DEF_BITS_PER_CATEGORY = 255;
    localparam int DEF_CHUNK             = 32;

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_DONE  = 1'b1
    } state_t;
endpackage

// File: rtl/popcount_chunk.sv
// popcount_chunk: combinational population count of one input beat.
//   data  [W-1:0]            bits to count
//   count [$clog2(W+1)-1:0]  number of ones in data
module popcount_chunk
    import lgn_pkg::*;
#(
    parameter  int W  = DEF_CHUNK,
    localparam int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  data,
    output logic [CW-1:0] count
);
    always_comb begin
        count = '0;
        for (int i = 0; i < W; i++)
            count = count + CW'(data[i]);
    end
endmodule

// File: rtl/seq_category_argmax.sv
// seq_category_argmax: streams per-class vote bits, popcounts each class and
// reports the class with the largest count (ties go to the lower index).
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid/in_ready      input beat handshake, in_data = CHUNK bits (LSB first)
//   out_valid/out_ready    result handshake
//   out_index, out_value   winning class and its popcount
//   out_margin             (only with ARGMAX_MARGIN_EN) best minus second-best sum
module seq_category_argmax
    import lgn_pkg::*;
#(
    parameter  int CATEGORIES        = DEF_CATEGORIES,
    parameter  int BITS_PER_CATEGORY = DEF_BITS_PER_CATEGORY,
    parameter  int CHUNK             = DEF_CHUNK,
    localparam int IDX_W             = $clog2(CATEGORIES),
    localparam int SUM_W             = $clog2(BITS_PER_CATEGORY + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CHUNK-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_index,
    output logic [SUM_W-1:0] out_value
`ifdef ARGMAX_MARGIN_EN
    ,
    output logic [SUM_W-1:0] out_margin
`endif
);
    localparam int BEATS     = (BITS_PER_CATEGORY + CHUNK - 1) / CHUNK;
    localparam int BW        = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PC_W      = $clog2(CHUNK + 1);
    localparam int LAST_BITS = BITS_PER_CATEGORY - (BEATS - 1) * CHUNK;
    // Only the low LAST_BITS bits of a category's final beat are real votes.
    localparam logic [CHUNK-1:0] LAST_MASK = {CHUNK{1'b1}} >> (CHUNK - LAST_BITS);

    state_t           state;
    logic [BW-1:0]    beat_cnt;
    logic [IDX_W-1:0] cat_cnt;
    logic [SUM_W-1:0] acc;
    logic [SUM_W-1:0] best_value;
    logic [IDX_W-1:0] best_index;
    logic [PC_W-1:0]  pc;
    logic [CHUNK-1:0] masked;
    logic             last_beat;
    logic             last_cat;
    logic             take;
    logic [SUM_W-1:0] sum_next;
    logic [SUM_W-1:0] best_value_next;
    logic [IDX_W-1:0] best_index_next;

    assign in_ready  = (state == ST_ACCUM);
    assign out_valid = (state == ST_DONE);
    assign last_beat = (beat_cnt == BW'(BEATS - 1));
    assign last_cat  = (cat_cnt == IDX_W'(CATEGORIES - 1));
    assign masked    = last_beat ? (in_data & LAST_MASK) : in_data;

    popcount_chunk #(.W(CHUNK)) u_pop (
        .data  (masked),
        .count (pc)
    );

    // Category 0 seeds the best unconditionally; later ones must be strictly greater.
    always_comb begin
        sum_next        = acc + SUM_W'(pc);
        take            = (cat_cnt == '0) || (sum_next > best_value);
        best_value_next = take ? sum_next : best_value;
        best_index_next = take ? cat_cnt : best_index;
    end

`ifdef ARGMAX_MARGIN_EN
    logic [SUM_W-1:0] second_value;
    logic [SUM_W-1:0] second_next;

    // Runner-up is the max of every sum that did not become the best; a tie
    // with the best lands here, giving a zero margin.
    always_comb begin
        second_next = (cat_cnt == '0) ? '0 :
                      take ? best_value :
                      (sum_next > second_value) ? sum_next : second_value;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            second_value <= '0;
            out_margin   <= '0;
        end else if (state == ST_ACCUM && in_valid && last_beat) begin
            second_value <= second_next;
            if (last_cat)
                out_margin <= best_value_next - second_next;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_ACCUM;
            beat_cnt   <= '0;
            cat_cnt    <= '0;
            acc        <= '0;
            best_value <= '0;
            best_index <= '0;
            out_index  <= '0;
            out_value  <= '0;
        end else if (state == ST_DONE) begin
            if (out_ready) begin
                state    <= ST_ACCUM;
                beat_cnt <= '0;
                cat_cnt  <= '0;
                acc      <= '0;
            end
        end else if (in_valid) begin
            if (!last_beat) begin
                acc      <= sum_next;
                beat_cnt <= beat_cnt + 1'b1;
            end else begin
                acc        <= '0;
                beat_cnt   <= '0;
                best_value <= best_value_next;
                best_index <= best_index_next;
                if (last_cat) begin
                    state     <= ST_DONE;
                    cat_cnt   <= '0;
                    out_value <= best_value_next;
                    out_index <= best_index_next;
                end else begin
                    cat_cnt <= cat_cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_seq_category_argmax.sv
// tb_seq_category_argmax: directed checks of seq_category_argmax at default parameters
// (10 classes, 255 bits, 32-bit beats, 8 beats per class). Margin checks when ARGMAX_MARGIN_EN.
module tb_seq_category_argmax;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  out_index;
    logic [7:0]  out_value;
`ifdef ARGMAX_MARGIN_EN
    logic [7:0]  out_margin;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int counts[10];
    bit ff_mode  = 1'b0;

    seq_category_argmax dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_index (out_index),
        .out_value (out_value)
`ifdef ARGMAX_MARGIN_EN
        ,
        .out_margin(out_margin)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // Class with count n has its lowest n bits set; ff_mode sets only the whole final beat.
    function automatic logic [31:0] beat_word(input int c, input int b);
        int k;
        if (ff_mode) return (b == 7) ? 32'hFFFF_FFFF : 32'h0;
        k = counts[c] - b * 32;
        if (k <= 0) return 32'h0;
        if (k >= 32) return 32'hFFFF_FFFF;
        return (32'h1 << k) - 32'h1;
    endfunction

    task automatic send_frame(input bit gaps, input int nbeats);
        for (int c = 0; c < 10; c++) begin
            for (int b = 0; b < 8; b++) begin
                if (c * 8 + b >= nbeats) return;
                if (gaps) begin
                    while ($urandom_range(0, 2) == 0) begin
                        in_valid = 1'b0;
                        in_data  = $urandom;
                        @(posedge clk); #1;
                    end
                end
                if (c * 8 + b == 79) begin
                    check("pre_last_out_valid", out_valid, 0);
                    check("pre_last_in_ready", in_ready, 1);
                end
                in_valid = 1'b1;
                in_data  = beat_word(c, b);
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic expect_result(input string tag, input int idx, input int val, input int mar);
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_index"}, out_index, idx);
        check({tag, "_value"}, out_value, val);
`ifdef ARGMAX_MARGIN_EN
        check({tag, "_margin"}, out_margin, mar);
`else
        if (mar < 0) check({tag, "_margin_arg"}, mar, 0);
`endif
    endtask

    task automatic consume(input string tag, input int idx, input int val);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_cons_valid"}, out_valid, 0);
        check({tag, "_cons_ready"}, in_ready, 1);
        check({tag, "_held_index"}, out_index, idx);
        check({tag, "_held_value"}, out_value, val);
    endtask

    task automatic model(output int idx, output int val, output int mar);
        int sec;
        idx = 0;
        val = counts[0];
        sec = 0;
        for (int c = 1; c < 10; c++) begin
            if (counts[c] > val) begin
                sec = val;
                val = counts[c];
                idx = c;
            end else if (counts[c] > sec) begin
                sec = counts[c];
            end
        end
        mar = val - sec;
    endtask

    initial begin
        int e_idx, e_val, e_mar;
        int rc[2][10];
        #12;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_index", out_index, 0);
        check("rst_out_value", out_value, 0);

        // class 3 all ones
        foreach (counts[c]) counts[c] = 0;
        counts[3] = 255;
        send_frame(1'b0, 80);
        expect_result("t31", 3, 255, 255);
        consume("t31", 3, 255);

        // only final beat all ones: MSB masked, every class 31, tie -> class 0
        ff_mode = 1'b1;
        send_frame(1'b0, 80);
        ff_mode = 1'b0;
        expect_result("t32", 0, 31, 0);
        consume("t32", 0, 31);

        // tie between classes 2 and 7 at 100, others 50
        foreach (counts[c]) counts[c] = 50;
        counts[2] = 100;
        counts[7] = 100;
        send_frame(1'b0, 80);
        expect_result("t33", 2, 100, 0);

        // hold result with out_ready low while junk beats are offered
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 32'hFFFF_FFFF;
            @(posedge clk); #1;
            expect_result("t34", 2, 100, 0);
        end
        in_valid = 1'b0;
        consume("t34", 2, 100);

        // reset after a partial frame, then full frame
        foreach (counts[c]) counts[c] = 255;
        send_frame(1'b0, 37);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #3;
        check("t35_rst_valid", out_valid, 0);
        check("t35_rst_index", out_index, 0);
        check("t35_rst_value", out_value, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("t35_rst_ready", in_ready, 1);
        foreach (counts[c]) counts[c] = 10;
        counts[9] = 200;
        send_frame(1'b0, 80);
        expect_result("t35", 9, 200, 190);
        consume("t35", 9, 200);

        // two back-to-back frames with random in_valid gaps vs reference model
        foreach (rc[f, c]) rc[f][c] = $urandom_range(0, 255);
        for (int f = 0; f < 2; f++) begin
            foreach (counts[c]) counts[c] = rc[f][c];
            model(e_idx, e_val, e_mar);
            send_frame(1'b1, 80);
            expect_result($sformatf("t36_f%0d", f), e_idx, e_val, e_mar);
            consume($sformatf("t36_f%0d", f), e_idx, e_val);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/seq_category_argmax.md
SEQ_CATEGORY_ARGMAX -- requirements
Module: seq_category_argmax

Interface
REQ-001 SHALL have parameter CATEGORIES, default 10, number of output classes (>=2).
REQ-002 SHALL have parameter BITS_PER_CATEGORY, default 255, gate-output bits voting for each class.
REQ-003 SHALL have parameter CHUNK, default 32, bits delivered per input beat (1..BITS_PER_CATEGORY).
REQ-004 SHALL have port clk, input, 1, single clock; all state changes on posedge.
REQ-005 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid, input, 1, in_data carries a beat.
REQ-007 SHALL have port in_ready, output, 1, block accepts a beat this cycle.
REQ-008 SHALL have port in_data, input, CHUNK, category bits, LSB = lowest bit index.
REQ-009 SHALL have port out_valid, output, 1, result held and valid.
REQ-010 SHALL have port out_ready, input, 1, consumer takes result.
REQ-011 SHALL have port out_index, output, IDX_W = $clog2(CATEGORIES), winning class.
REQ-012 SHALL have port out_value, output, SUM_W = $clog2(BITS_PER_CATEGORY+1), winning popcount.

Function
REQ-013 SHALL define BEATS = ceil(BITS_PER_CATEGORY/CHUNK) beats per category; categories arrive in order 0..CATEGORIES-1, CATEGORIES*BEATS beats per frame.
REQ-014 SHALL, on final beat of a category, mask in_data bits at positions >= BITS_PER_CATEGORY-(BEATS-1)*CHUNK to zero before counting.
REQ-015 SHALL accept a beat when in_valid && in_ready, add its popcount into running SUM_W-bit category accumulator; no overflow possible by construction.
REQ-016 SHALL run two-state FSM: ACCUM (in_ready=1, out_valid=0) and DONE (in_ready=0, out_valid=1).
REQ-017 SHALL, at end of each category, compare completed sum with running best: strictly greater replaces best value/index; ties keep lower index.
REQ-018 SHALL treat category 0 sum as initial best unconditionally.
REQ-019 SHALL transition ACCUM->DONE on acceptance of final beat of final category; out_valid high the next cycle (latency 1 cycle after last beat).
REQ-020 SHALL hold out_index/out_value stable while out_valid && !out_ready.
REQ-021 SHALL transition DONE->ACCUM on out_valid && out_ready; clear beat counter, category counter, accumulator; in_ready high next cycle.
REQ-022 SHALL ignore in_data/in_valid when in_ready=0; in_valid gaps mid-frame stall counting without loss.
REQ-023 SHALL keep out_index/out_value at last result while in ACCUM (not updated until next DONE).

Reset
REQ-024 SHALL on rst_n=0 asynchronously force ACCUM, all counters/accumulators/best registers to 0, out_valid=0, out_index=0, out_value=0, in_ready=1 after deassertion.
REQ-025 SHALL abandon any partial frame on reset mid-frame; next accepted beat is beat 0 of category 0.

Configuration
REQ-026 SHALL with ARGMAX_MARGIN_EN defined add output out_margin (SUM_W) = best minus second-best sum, tracked with same tie rule, reset 0, held with out_value.
REQ-027 SHALL without ARGMAX_MARGIN_EN have no out_margin port and no second-best registers.

Structure
REQ-028 SHALL place in shared package lgn_pkg: default CATEGORIES/BITS_PER_CATEGORY/CHUNK constants, FSM state enum type.
REQ-029 SHALL instantiate one sub-module popcount_chunk (CHUNK in, $clog2(CHUNK+1) out, combinational).
REQ-030 SHALL compute IDX_W, SUM_W, BEATS as localparams from parameters.

Verification (defaults: 10 classes, 255 bits, CHUNK=32, BEATS=8)
REQ-031 SHALL test: class 3 all ones, others all zero, in_valid constant -> out_valid 1 cycle after beat 79, out_index=3, out_value=255.
REQ-032 SHALL test: final beat of every class 32'hFFFF_FFFF, others zero -> per-class sum 31 (MSB masked), tie -> out_index=0, out_value=31.
REQ-033 SHALL test: classes 2 and 7 both sum 100, others 50 -> out_index=2, out_value=100; with ARGMAX_MARGIN_EN out_margin=0.
REQ-034 SHALL test: out_ready low 5 cycles after result -> out_valid, out_index, out_value stable, in_ready=0, extra in_valid beats ignored.
REQ-035 SHALL test: rst_n pulsed low after 37 beats, then full frame with class 9 = 200, rest 10 -> out_index=9, out_value=200 (margin 190).
REQ-036 SHALL test: random in_valid gaps across two back-to-back frames -> results identical to gap-free reference model.
